// File: rtl/pixel_unpack.sv
// pixel_unpack: unpacks framebuffer words into 8/4/2/1 bpp palette indices, one per clock under display enable
module pixel_unpack #(
  parameter int WIDTH = 32
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic [1:0]       mode_i,
  input  logic             line_start_i,
  input  logic             de_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [7:0]       colour_o,
  output logic             de_o,
  output logic             underrun_o,
  input  logic             clear_i
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [1:0]       mode_q, mode_e;
  logic [WIDTH-1:0] hold, shift;
  logic             hold_full, started, take, accept, starve;
  logic [CW-1:0]    cnt, cnt_e, ppw;
  logic [3:0]       bpp;
  logic [7:0]       mask;
  // line_start flushes the shift reg and latches the mode before this cycle's pixel is chosen
  always_comb begin
    mode_e = line_start_i ? mode_i : mode_q;
    cnt_e  = line_start_i ? '0 : cnt;
    bpp    = 4'd8 >> mode_e;
    mask   = 8'hff >> (4'd8 - bpp);
    ppw    = CW'(WIDTH) >> (2'd3 - mode_e);
    take   = (cnt_e == '0) && hold_full;
    starve = de_i && (cnt_e == '0) && !hold_full;
    accept = valid_i && ready_o;
  end
  assign ready_o = started & ~hold_full;
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      mode_q     <= 2'b00;
      hold       <= '0;
      shift      <= '0;
      hold_full  <= 1'b0;
      started    <= 1'b0;
      cnt        <= '0;
      colour_o   <= 8'h00;
      de_o       <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      started    <= 1'b1;
      de_o       <= de_i;
      if (line_start_i) mode_q <= mode_i;
      hold_full  <= accept | (hold_full & ~take);
      if (accept) hold <= data_i;
      cnt        <= cnt_e;
      underrun_o <= (underrun_o & ~clear_i) | starve;
      if (de_i) begin
        if (cnt_e != '0) begin
          colour_o <= shift[7:0] & mask;
          shift    <= shift >> bpp;
          cnt      <= cnt_e - CW'(1);
        end else if (hold_full) begin
          colour_o <= hold[7:0] & mask;
          shift    <= hold >> bpp;
          cnt      <= ppw - CW'(1);
        end else begin
          colour_o <= 8'h00;
        end
      end else if (take) begin
        shift <= hold;
        cnt   <= ppw;
      end
    end
  end
endmodule

// File: tb/tb_pixel_unpack.sv
// tb_pixel_unpack: table-driven lines plus hand-written corner sequences, scoreboard on de_o
module tb_pixel_unpack;
  logic        clk = 0, rst_n = 0;
  logic [1:0]  mode = 0;
  logic        line_start = 0, de = 0, valid = 0, clear = 0;
  logic [31:0] data = 0;
  logic        ready, de_out, underrun;
  logic [7:0]  colour;
  int          checks = 0, errors = 0, acc = 0;
  logic [7:0]  q[$];

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] word;
    int          n;
    logic [63:0] exp;
  } vec_t;
  vec_t tbl[7];

  pixel_unpack #(.WIDTH(32)) dut (
    .clock_i(clk), .reset_ni(rst_n), .mode_i(mode), .line_start_i(line_start),
    .de_i(de), .data_i(data), .valid_i(valid), .ready_o(ready),
    .colour_o(colour), .de_o(de_out), .underrun_o(underrun), .clear_i(clear)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (rst_n && valid && ready) acc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    logic d;
    logic [7:0] e;
    d = de;
    @(posedge clk);
    #1;
    chk("de_o", de_out, d);
    if (de_out) begin
      if (q.size() == 0) chk("unexpected_pixel", 1, 0);
      else begin
        e = q.pop_front();
        chk("colour", colour, e);
      end
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    bit ok = 0;
    valid = 1;
    data = w;
    for (int k = 0; k < 16 && !ok; k++) begin
      ok = ready;
      tick();
    end
    valid = 0;
    if (!ok) chk("ready_timeout", 0, 1);
  endtask

  task automatic line(input logic [1:0] m);
    de = 0;
    line_start = 1;
    mode = m;
    tick();
    line_start = 0;
  endtask

  task automatic play(input logic [7:0] e);
    de = 1;
    q.push_back(e);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int a0;
    tbl[0] = '{2'd0, 32'h03020100, 4, 64'h0000_0000_0302_0100};
    tbl[1] = '{2'd1, 32'h76543210, 8, 64'h0706_0504_0302_0100};
    tbl[2] = '{2'd2, 32'h0000_00E4, 4, 64'h0000_0000_0302_0100};
    tbl[3] = '{2'd3, 32'h0000_0005, 8, 64'h0000_0000_0001_0001};
    tbl[4] = '{2'd0, 32'hA5C3_FF80, 4, 64'h0000_0000_A5C3_FF80};
    tbl[5] = '{2'd1, 32'h0000_00F9, 8, 64'h0000_0000_0000_0F09};
    tbl[6] = '{2'd2, 32'h0000_001B, 4, 64'h0000_0000_0001_0203};

    #3;
    chk("rst_colour", colour, 0);
    chk("rst_de_o", de_out, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_ready", ready, 0);
    @(negedge clk);
    rst_n = 1;
    tick();
    chk("ready_after_release", ready, 1);

    foreach (tbl[r]) begin
      line(tbl[r].mode);
      a0 = acc;
      push_word(tbl[r].word);
      tick();
      for (int i = 0; i < tbl[r].n; i++) play(tbl[r].exp[i*8 +: 8]);
      de = 0;
      tick();
      chk("words_consumed", acc - a0, 1);
      chk("row_underrun", underrun, 0);
    end

    line(2'd0);
    push_word(32'h03020100);
    tick();
    push_word(32'h07060504);
    for (int i = 0; i < 8; i++) play(8'(i));
    de = 0;
    tick();
    chk("t1_underrun", underrun, 0);
    chk("t1_ready", ready, 1);

    line(2'd3);
    push_word(32'h0000_0005);
    tick();
    mode = 2'd0;
    for (int i = 0; i < 32; i++) play((i == 0 || i == 2) ? 8'h01 : 8'h00);
    de = 0;
    tick();
    chk("t3_underrun", underrun, 0);

    line(2'd0);
    for (int i = 0; i < 3; i++) play(8'h00);
    de = 0;
    tick();
    chk("t4_underrun_set", underrun, 1);
    tick();
    chk("t4_underrun_sticky", underrun, 1);
    clear = 1;
    play(8'h00);
    clear = 0;
    de = 0;
    chk("t4_set_wins", underrun, 1);
    clear = 1;
    tick();
    clear = 0;
    chk("t4_cleared", underrun, 0);

    line(2'd0);
    push_word(32'h44332211);
    tick();
    push_word(32'h88776655);
    play(8'h11);
    play(8'h22);
    de = 0;
    tick();
    line(2'd0);
    play(8'h55);
    play(8'h66);
    play(8'h77);
    play(8'h88);
    de = 0;
    tick();
    chk("t5_underrun", underrun, 0);
    push_word(32'h44332211);
    tick();
    push_word(32'hDDCCBBAA);
    play(8'h11);
    line_start = 1;
    play(8'hAA);
    line_start = 0;
    play(8'hBB);
    de = 0;
    tick();
    chk("t5b_underrun", underrun, 0);

    line(2'd0);
    push_word(32'h44332211);
    tick();
    push_word(32'h88776655);
    play(8'h11);
    play(8'h22);
    #3;
    rst_n = 0;
    #1;
    chk("t6_colour", colour, 0);
    chk("t6_de_o", de_out, 0);
    chk("t6_underrun", underrun, 0);
    chk("t6_ready", ready, 0);
    de = 0;
    q.delete();
    @(negedge clk);
    rst_n = 1;
    tick();
    chk("t6_ready_release", ready, 1);
    line(2'd1);
    push_word(32'h76543210);
    tick();
    for (int i = 0; i < 8; i++) play(8'(i));
    de = 0;
    tick();
    chk("t6_underrun_after", underrun, 0);
    chk("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
